// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive controllers:
// FSM state encoding, oversampling ratio and default frame parameters.
package uart_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int DEF_DBITS    = 8;
    localparam int DEF_SB_TICKS = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_t;

    // A stop period longer than one bit needs a fifth tick-counter bit.
    function automatic int tick_cnt_width(input int sb_ticks);
        return (sb_ticks > OVERSAMPLE) ? 5 : 4;
    endfunction

endpackage

// File: rtl/uart_tx_shreg.sv
// Transmit data register: parallel load, shift right toward the LSB, and a
// running parity flop folded with every bit that leaves position 0.
module uart_tx_shreg
    import uart_pkg::*;
#(
    parameter int   DBITS    = DEF_DBITS,
    parameter logic PAR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [DBITS-1:0] din,
    output logic             lsb,
    output logic             par
);

    logic [DBITS-1:0] b_reg;
    logic [DBITS-1:0] b_next;
    logic             par_reg;
    logic             par_next;
    logic [DBITS-1:0] shifted;

    for (genvar gi = 0; gi < DBITS; gi++) begin : g_shift
        if (gi == DBITS - 1) begin : g_msb
            assign shifted[gi] = 1'b0;
        end else begin : g_bit
            assign shifted[gi] = b_reg[gi+1];
        end
    end

    always_comb begin
        b_next   = b_reg;
        par_next = par_reg;
        if (load) begin
            b_next   = din;
            par_next = PAR_INIT;
        end else if (shift) begin
            b_next   = shifted;
            par_next = par_reg ^ b_reg[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_reg   <= '0;
            par_reg <= 1'b0;
        end else begin
            b_reg   <= b_next;
            par_reg <= par_next;
        end
    end

    // Both outputs present the post-edge values so the controller can
    // register tx on the same edge that loads or shifts this register.
    assign lsb = b_next[0];
    assign par = par_next;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one frame (start, data LSB-first,
// optional parity, stop) paced by the 16x oversampling tick.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DBITS      = DEF_DBITS,
    parameter int SB_TICKS   = DEF_SB_TICKS,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [DBITS-1:0] din,
    output logic             tmr_en,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             tx
);

    localparam int SW = tick_cnt_width(SB_TICKS);
    localparam int NW = $clog2(DBITS);

    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBITS - 1);

    uart_state_t   state_reg;
    uart_state_t   state_next;
    logic [SW-1:0] s_cnt_reg;
    logic [SW-1:0] s_cnt_next;
    logic [NW-1:0] n_cnt_reg;
    logic [NW-1:0] n_cnt_next;
    logic          tx_reg;
    logic          tx_next;
    logic          busy_reg;
    logic          busy_next;
    logic          tmr_en_reg;
    logic          tmr_en_next;
    logic          done_reg;
    logic          done_next;

    logic          sh_load;
    logic          sh_shift;
    logic          sh_lsb;
    logic          sh_par;

    uart_tx_shreg #(
        .DBITS    (DBITS),
        .PAR_INIT (PARITY_ODD != 0)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (din),
        .lsb   (sh_lsb),
        .par   (sh_par)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            s_cnt_reg  <= '0;
            n_cnt_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            tmr_en_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            s_cnt_reg  <= s_cnt_next;
            n_cnt_reg  <= n_cnt_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            tmr_en_reg <= tmr_en_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_cnt_next = s_cnt_reg;
        n_cnt_next = n_cnt_reg;
        done_next  = 1'b0;
        sh_load    = 1'b0;
        sh_shift   = 1'b0;

        case (state_reg)
            IDLE: begin
                // busy_reg is still high during the done cycle, which holds
                // off a back-to-back request for exactly one clock.
                if (tx_start && !busy_reg) begin
                    sh_load    = 1'b1;
                    s_cnt_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_reg == BIT_LAST) begin
                        s_cnt_next = '0;
                        n_cnt_next = '0;
                        state_next = DATA;
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_reg == BIT_LAST) begin
                        s_cnt_next = '0;
                        sh_shift   = 1'b1;
                        if (n_cnt_reg == N_LAST) begin
                            state_next = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_cnt_next = n_cnt_reg + NW'(1);
                        end
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_reg == BIT_LAST) begin
                        s_cnt_next = '0;
                        state_next = STOP;
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_reg == STOP_LAST) begin
                        s_cnt_next = '0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_cnt_next = s_cnt_reg + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                s_cnt_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the transition that causes them.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_lsb;
            PARITY:  tx_next = sh_par;
            default: tx_next = 1'b1;
        endcase
        busy_next   = (state_next != IDLE) || done_next;
        tmr_en_next = (state_next != IDLE) || done_next;
    end

    assign tx           = tx_reg;
    assign tx_busy      = busy_reg;
    assign tmr_en       = tmr_en_reg;
    assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised bench for uart_tx_ctrl: three parameterisations checked cycle by
// cycle against a tick-counting frame model.
module tb_uart_tx_ctrl;

    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic [2:0] reset = 3'b111;
    logic [2:0] s_tick = '0;
    logic [2:0] tx_start = '0;
    logic [8:0] din_v [3];
    logic [2:0] tmr_en;
    logic [2:0] tx_busy;
    logic [2:0] tx_done_tick;
    logic [2:0] tx;

    int p_dbits [3] = '{8, 8, 7};
    int p_pe    [3] = '{0, 1, 1};
    int p_po    [3] = '{0, 0, 1};
    int p_sb    [3] = '{16, 16, 32};

    int n_checks = 0;
    int n_fail   = 0;
    int tick_phase = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DBITS(8), .SB_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .reset(reset[0]), .s_tick(s_tick[0]), .tx_start(tx_start[0]),
        .din(din_v[0][7:0]), .tmr_en(tmr_en[0]), .tx_busy(tx_busy[0]),
        .tx_done_tick(tx_done_tick[0]), .tx(tx[0])
    );

    uart_tx_ctrl #(.DBITS(8), .SB_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .reset(reset[1]), .s_tick(s_tick[1]), .tx_start(tx_start[1]),
        .din(din_v[1][7:0]), .tmr_en(tmr_en[1]), .tx_busy(tx_busy[1]),
        .tx_done_tick(tx_done_tick[1]), .tx(tx[1])
    );

    uart_tx_ctrl #(.DBITS(7), .SB_TICKS(32), .PARITY_EN(1), .PARITY_ODD(1)) u_7o2 (
        .clk(clk), .reset(reset[2]), .s_tick(s_tick[2]), .tx_start(tx_start[2]),
        .din(din_v[2][6:0]), .tmr_en(tmr_en[2]), .tx_busy(tx_busy[2]),
        .tx_done_tick(tx_done_tick[2]), .tx(tx[2])
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed observation: {tx, tx_busy, tmr_en, tx_done_tick}
    function automatic int observe(input int sel);
        return int'({tx[sel], tx_busy[sel], tmr_en[sel], tx_done_tick[sel]});
    endfunction

    // Line level for bit slot idx of a frame: start, data LSB-first, parity, stop.
    function automatic int line_bit(input int sel, input int data, input int idx);
        int d;
        int ones;
        d = p_dbits[sel];
        if (idx == 0) return 0;
        if (idx <= d) return (data >> (idx - 1)) & 1;
        if (p_pe[sel] != 0 && idx == d + 1) begin
            ones = 0;
            for (int i = 0; i < d; i++) ones += (data >> i) & 1;
            return (p_po[sel] != 0) ? 1 - (ones % 2) : ones % 2;
        end
        return 1;
    endfunction

    // mode 0: tick every clock, 1: every 4th clock, 2: random ~1/3
    function automatic logic gen_tick(input int mode);
        tick_phase++;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (tick_phase % 4) == 0;
        return $urandom_range(0, 2) == 0;
    endfunction

    // Entered and left at a negedge. Requests a frame now, then checks every
    // cycle until one clock after tx_done_tick, or aborts by reset at abort_t.
    task automatic run_frame(input int sel, input int data, input int mode,
                             input bit hold, input bit noise, input int abort_t);
        int  nbits, nfr, t, cyc, done_obs, n_done;
        bit  post, fin, aborted;
        int  exp_v, got_v;
        nbits    = 1 + p_dbits[sel] + p_pe[sel];
        nfr      = 16 * nbits + p_sb[sel];
        t        = 0;
        cyc      = -1;
        done_obs = -1;
        n_done   = 0;
        post     = 1'b0;
        fin      = 1'b0;
        aborted  = 1'b0;
        din_v[sel]    = 9'(data);
        tx_start[sel] = 1'b1;
        s_tick[sel]   = gen_tick(mode);
        while (!fin && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            got_v = observe(sel);
            if (post)          exp_v = 4'b1000;
            else if (t == nfr) exp_v = 4'b1111;
            else               exp_v = (line_bit(sel, data, t / 16) << 3) | 4'b0110;
            check_eq("frame", got_v, exp_v);
            if (tx_done_tick[sel]) begin
                n_done++;
                if (done_obs < 0) done_obs = cyc;
            end
            if (abort_t != 0 && t == abort_t && !aborted) begin
                aborted = 1'b1;
                reset[sel]    = 1'b0;
                s_tick[sel]   = 1'b0;
                tx_start[sel] = 1'b0;
                #2;
                check_eq("async_reset", observe(sel), 4'b1000);
                @(negedge clk);
                check_eq("reset_hold", observe(sel), 4'b1000);
                reset[sel] = 1'b1;
                break;
            end
            if (post) begin
                fin = 1'b1;
            end else if (t == nfr) begin
                post = 1'b1;
            end
            if (fin) begin
                tx_start[sel] = hold;
            end else begin
                s_tick[sel] = gen_tick(mode);
                if (s_tick[sel] && t < nfr) t++;
                if (hold) begin
                    tx_start[sel] = 1'b1;
                end else if (noise) begin
                    tx_start[sel] = ($urandom_range(0, 3) == 0);
                    din_v[sel]    = 9'($urandom);
                end else begin
                    tx_start[sel] = 1'b0;
                end
            end
        end
        if (!aborted) begin
            check_eq("frame_end", int'(fin), 1);
            check_eq("done_pulses", n_done, 1);
            if (mode == 0) check_eq("done_cycle", done_obs, nfr);
        end
        $display("frame sel=%0d data=0x%02h mode=%0d hold=%0d noise=%0d abort=%0d cycles=%0d",
                 sel, data, mode, hold, noise, abort_t, cyc);
    endtask

    task automatic idle_check(input int sel, input int n);
        tx_start[sel] = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_tick[sel] = $urandom_range(0, 1) == 1;
            din_v[sel]  = 9'($urandom);
            @(negedge clk);
            check_eq("idle", observe(sel), 4'b1000);
        end
        s_tick[sel] = 1'b0;
        $display("idle sel=%0d cycles=%0d", sel, n);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) din_v[s] = '0;
        #1 reset = 3'b000;
        #1;
        for (int s = 0; s < 3; s++) check_eq("reset_state", observe(s), 4'b1000);
        repeat (3) @(negedge clk);
        reset = 3'b111;

        for (int s = 0; s < 3; s++) idle_check(s, 20);

        run_frame(0, 'hA5, 0, 1'b0, 1'b0, 0);
        run_frame(1, 'h07, 0, 1'b0, 1'b0, 0);
        run_frame(2, 'h07, 0, 1'b0, 1'b0, 0);
        run_frame(2, 'h00, 1, 1'b0, 1'b0, 0);
        run_frame(0, 'h5A, 2, 1'b0, 1'b1, 0);
        run_frame(1, 'h33, 0, 1'b1, 1'b0, 0);
        run_frame(1, 'hC4, 2, 1'b0, 1'b0, 0);
        run_frame(0, 'hFF, 0, 1'b0, 1'b0, 72);
        run_frame(0, 'h3C, 0, 1'b0, 1'b0, 0);
        run_frame(2, 'h55, 2, 1'b0, 1'b1, 72);
        run_frame(2, 'h3C, 1, 1'b0, 1'b0, 0);
        idle_check(0, 10);

        for (int i = 0; i < 12; i++) begin
            int sel;
            bit hold;
            sel  = $urandom_range(0, 2);
            hold = $urandom_range(0, 1) == 1;
            run_frame(sel, int'($urandom & 'h1FF), $urandom_range(0, 2), hold,
                      $urandom_range(0, 1) == 1, 0);
            if (hold)
                run_frame(sel, int'($urandom & 'h1FF), $urandom_range(0, 2), 1'b0,
                          $urandom_range(0, 1) == 1, 0);
        end
        idle_check(1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
